// File: rtl/alu8_cmd_issue_stage.sv
// alu8_cmd_issue_stage: command FIFO plus a two-stage issue/response pipeline
// in front of a purely combinational 8-bit ALU.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready is combinational)
//   cmd_opcode/a/b/shift     command payload
//   alu_opcode/input1/input2/shiftValue  registered drives into the ALU (stage D)
//   alu_result/alu_carryFlag combinational ALU outputs
//   rsp_valid/rsp_ready      response handshake (stage R)
//   rsp_result/carry/err/tag captured response payload
//   fifo_count               entries currently held in the command FIFO
module alu8_cmd_issue_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [4:0]               cmd_shift,
  output logic [3:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_input1,
  output logic [WIDTH-1:0]         alu_input2,
  output logic [4:0]               alu_shiftValue,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carryFlag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_err,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SH_W  = 5;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = OP_W + 2 * WIDTH + SH_W + TAG_W;

  // Field offsets inside a FIFO entry {opcode, a, b, shift, tag}
  localparam int unsigned SH_LSB = TAG_W;
  localparam int unsigned B_LSB  = SH_LSB + SH_W;
  localparam int unsigned A_LSB  = B_LSB + WIDTH;
  localparam int unsigned OP_LSB = A_LSB + WIDTH;

  localparam logic [OP_W-1:0] OP_ADD     = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB     = 4'd1;
  localparam logic [OP_W-1:0] OP_MAX_LEG = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_t;

  stage_t d_state, d_state_nxt;
  stage_t r_state, r_state_nxt;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] d_tag;
  logic [ENT_W-1:0] head;

  logic d_v;
  logic fifo_nonempty;
  logic push;
  logic d_load;
  logic r_load;

  assign d_v           = (d_state == ST_FULL);
  assign rsp_valid     = (r_state == ST_FULL);
  assign fifo_nonempty = (fifo_count != '0);
  assign head          = mem[rd_ptr];

  // Handshake and stage-load decisions; d_load doubles as the FIFO pop
  assign r_load    = d_v && (!rsp_valid || rsp_ready);
  assign d_load    = fifo_nonempty && (!d_v || r_load);
  assign cmd_ready = (fifo_count < CNT_W'(DEPTH)) || d_load;
  assign push      = cmd_valid && cmd_ready;

  // Stage next-state logic (each stage is simply EMPTY or FULL)
  always_comb begin
    d_state_nxt = d_state;
    r_state_nxt = r_state;
    if (d_load) begin
      d_state_nxt = ST_FULL;
    end else if (r_load) begin
      d_state_nxt = ST_EMPTY;
    end
    if (r_load) begin
      r_state_nxt = ST_FULL;
    end else if (rsp_valid && rsp_ready) begin
      r_state_nxt = ST_EMPTY;
    end
  end

  // Stage state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state <= ST_EMPTY;
      r_state <= ST_EMPTY;
    end else begin
      d_state <= d_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // FIFO storage; contents need no reset since pointers/count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b, cmd_shift, tag_cnt};
    end
  end

  // FIFO pointers, occupancy and sequence tag counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tag_cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (d_load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, d_load})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue stage D: registered drive into the combinational ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      d_tag          <= '0;
    end else if (d_load) begin
      alu_opcode     <= head[OP_LSB +: OP_W];
      alu_input1     <= head[A_LSB +: WIDTH];
      alu_input2     <= head[B_LSB +: WIDTH];
      alu_shiftValue <= head[SH_LSB +: SH_W];
      d_tag          <= head[TAG_W-1:0];
    end
  end

  // Response stage R: capture ALU output; carry only meaningful for ADD/SUB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else if (r_load) begin
      rsp_tag <= d_tag;
      if (alu_opcode > OP_MAX_LEG) begin
        rsp_err    <= 1'b1;
        rsp_result <= '0;
        rsp_carry  <= 1'b0;
      end else begin
        rsp_err    <= 1'b0;
        rsp_result <= alu_result;
        rsp_carry  <= ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) ? alu_carryFlag : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu8_cmd_issue_stage.sv
// Directed testbench for alu8_cmd_issue_stage with a behavioural 8-bit ALU.
module tb_alu8_cmd_issue_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [4:0] cmd_shift = '0;
  logic [3:0] alu_opcode;
  logic [7:0] alu_input1;
  logic [7:0] alu_input2;
  logic [4:0] alu_shiftValue;
  logic [7:0] alu_result;
  logic       alu_carryFlag;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_err;
  logic [3:0] rsp_tag;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  alu8_cmd_issue_stage #(.DEPTH(4), .WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue),
    .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; non-arithmetic ops raise a stale carry so masking is visible
  logic [8:0] alu_sum;
  int         alu_rot;
  always_comb begin
    alu_sum       = '0;
    alu_rot       = int'(alu_shiftValue) % 8;
    alu_result    = 8'hAA;
    alu_carryFlag = 1'b1;
    case (alu_opcode)
      4'd0: begin alu_sum = {1'b0, alu_input1} + {1'b0, alu_input2}; alu_result = alu_sum[7:0]; alu_carryFlag = alu_sum[8]; end
      4'd1: begin alu_sum = {1'b0, alu_input1} - {1'b0, alu_input2}; alu_result = alu_sum[7:0]; alu_carryFlag = alu_sum[8]; end
      4'd2: alu_result = alu_input1 & alu_input2;
      4'd3: alu_result = alu_input1 | alu_input2;
      4'd4: alu_result = alu_input1 ^ alu_input2;
      4'd5: alu_result = ~alu_input1;
      4'd6: alu_result = (alu_input1 << alu_rot) | (alu_input1 >> (8 - alu_rot));
      4'd7: alu_result = (alu_input1 >> alu_rot) | (alu_input1 << (8 - alu_rot));
      4'd8: alu_result = alu_input1;
      4'd9: alu_result = alu_input2;
      default: alu_result = 8'hAA;
    endcase
  end

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one command starting at a negedge; returns at the negedge after acceptance
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [4:0] sh);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready never seen for opcode %0d", op);
    end
  endtask

  task automatic wait_rsp(input int max_cycles);
    int n;
    n = 0;
    while (!rsp_valid && n < max_cycles) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    checks++;
    if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== 25'd0) begin
      errors++; $display("FAIL reset_alu: op=%0d a=%h b=%h sh=%0d want all 0", alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    end
    checks++;
    if ({rsp_result, rsp_carry, rsp_err, rsp_tag} !== 14'd0) begin
      errors++; $display("FAIL reset_rsp: res=%h c=%0b e=%0b tag=%0d want all 0", rsp_result, rsp_carry, rsp_err, rsp_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 8'hF0; cmd_b = 8'h20; cmd_shift = 5'd3;
    @(posedge clk);   // t0 accept
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_t0_valid: got %0b want 0", rsp_valid); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_t0_count: got %0d want 1", fifo_count); end
    @(posedge clk);   // t1 into D
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %0b want 0", rsp_valid); end
    checks++;
    if (alu_opcode !== 4'd0 || alu_input1 !== 8'hF0 || alu_input2 !== 8'h20 || alu_shiftValue !== 5'd3) begin
      errors++; $display("FAIL single_t1_alu: op=%0d a=%h b=%h sh=%0d want 0 f0 20 3", alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    end
    @(posedge clk);   // t2 into R
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h10 || rsp_carry !== 1'b1 || rsp_err !== 1'b0 || rsp_tag !== 4'd0) begin
      errors++; $display("FAIL single_rsp: v=%0b res=%h c=%0b e=%0b tag=%0d want 1 10 1 0 0", rsp_valid, rsp_result, rsp_carry, rsp_err, rsp_tag);
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: rsp_valid=%0b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 1'b0;
    push_cmd(4'd1, 8'h05, 8'h06, 5'd0);
    push_cmd(4'd2, 8'hFF, 8'h0F, 5'd0);
    wait_rsp(10);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'hFF || rsp_carry !== 1'b1 || rsp_tag !== 4'd0 || rsp_err !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: v=%0b res=%h c=%0b tag=%0d want 1 ff 1 0", i, rsp_valid, rsp_result, rsp_carry, rsp_tag);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h0F || rsp_carry !== 1'b0 || rsp_tag !== 4'd1) begin
      errors++; $display("FAIL stall_next: v=%0b res=%h c=%0b tag=%0d want 1 0f 0 1", rsp_valid, rsp_result, rsp_carry, rsp_tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_fill_full();
    int accepted;
    int n;
    accepted = 0;
    n = 0;
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1; cmd_opcode = 4'd9; cmd_a = 8'h00; cmd_b = 8'(i); cmd_shift = 5'd0;
      #1;
      if (cmd_ready) accepted++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    #1;
    checks++; if (accepted != 6) begin errors++; $display("FAIL full_accepts: got %0d want 6", accepted); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", cmd_ready); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        checks++;
        if (n >= 6 || rsp_result !== 8'(n) || rsp_tag !== 4'(n)) begin
          errors++; $display("FAIL full_order[%0d]: res=%h tag=%0d want %h %0d", n, rsp_result, rsp_tag, 8'(n), n);
        end
        n++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (n != 6) begin errors++; $display("FAIL full_rsp_count: got %0d want 6", n); end
  endtask

  task automatic test_illegal();
    do_reset();
    rsp_ready = 1'b1;
    push_cmd(4'd12, 8'h33, 8'h44, 5'd0);
    wait_rsp(10);
    checks++;
    if (rsp_err !== 1'b1 || rsp_result !== 8'h00 || rsp_carry !== 1'b0 || rsp_tag !== 4'd0) begin
      errors++; $display("FAIL illegal_rsp: e=%0b res=%h c=%0b tag=%0d want 1 00 0 0", rsp_err, rsp_result, rsp_carry, rsp_tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 18; i++) push_cmd(4'd9, 8'h00, 8'(i), 5'd0);
      end
      begin
        wait_rsp(10);
        for (int i = 0; i < 18; i++) begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_result !== 8'(i) || rsp_tag !== 4'(i % 16)) begin
            errors++; $display("FAIL stream[%0d]: v=%0b res=%h tag=%0d want 1 %h %0d", i, rsp_valid, rsp_result, rsp_tag, 8'(i), i % 16);
          end
          @(posedge clk);
          @(negedge clk);
        end
      end
    join
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: rsp_valid=%0b want 0", rsp_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'd8, 8'(i + 1), 8'(i + 16), 5'd1);
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL arst_pre_count: got %0d want 3", fifo_count); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %0b want 1", rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b want 0", rsp_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", fifo_count); end
    checks++;
    if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== 25'd0) begin
      errors++; $display("FAIL arst_alu: op=%0d a=%h b=%h sh=%0d want all 0", alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    push_cmd(4'd9, 8'h00, 8'h5A, 5'd0);
    wait_rsp(10);
    checks++;
    if (rsp_tag !== 4'd0 || rsp_result !== 8'h5A) begin
      errors++; $display("FAIL arst_after: tag=%0d res=%h want 0 5a", rsp_tag, rsp_result);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_fill_full();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
